// File: rtl/load_controller.sv
// RV32I load unit: issues one aligned word read, then picks out the byte, half or word and extends it.
// Misaligned or illegal requests, and memory timeouts, complete with ld_err instead of data.
module load_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_start,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FAIL
  } state_t;

  // An unacknowledged REQ cycle that finds the counter here is the last one allowed.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [31:0] addr_q, addr_next;
  logic [2:0]  funct3_q, funct3_next;
  logic [7:0]  wait_cnt, wait_cnt_next;

  logic        mem_req_q, mem_req_next;
  logic [31:0] mem_addr_q, mem_addr_next;
  logic        busy_q, busy_next;
  logic        done_q, done_next;
  logic        err_q, err_next;
  logic [31:0] data_q, data_next;

  function automatic logic load_ok(input logic [1:0] lane, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~lane[0];
      3'b010:         ok = (lane == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] lane, input logic [2:0] f3,
                                              input logic [31:0] word);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   result = {{24{byte_sel[7] & ~f3[2]}}, byte_sel};
      2'b01:   result = {{16{half_sel[15] & ~f3[2]}}, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

  always_comb begin
    state_next    = state;
    addr_next     = addr_q;
    funct3_next   = funct3_q;
    wait_cnt_next = wait_cnt;
    data_next     = data_q;

    case (state)
      IDLE: begin
        if (ld_start) begin
          addr_next     = ld_addr;
          funct3_next   = ld_funct3;
          wait_cnt_next = '0;
          if (load_ok(ld_addr[1:0], ld_funct3)) begin
            state_next = REQ;
          end else begin
            state_next = FAIL;
            data_next  = '0;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_next = RESP;
          data_next  = extend_load(addr_q[1:0], funct3_q, mem_rdata);
        end else if (wait_cnt == LAST_WAIT) begin
          state_next    = FAIL;
          data_next     = '0;
          wait_cnt_next = wait_cnt + 8'd1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      RESP: state_next = IDLE;
      FAIL: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    mem_req_next  = (state_next == REQ);
    mem_addr_next = mem_req_next ? {addr_next[31:2], 2'b00} : '0;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == RESP) || (state_next == FAIL);
    err_next      = (state_next == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      wait_cnt   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state      <= state_next;
      addr_q     <= addr_next;
      funct3_q   <= funct3_next;
      wait_cnt   <= wait_cnt_next;
      mem_req_q  <= mem_req_next;
      mem_addr_q <= mem_addr_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
      err_q      <= err_next;
      data_q     <= data_next;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ld_busy  = busy_q;
  assign ld_done  = done_q;
  assign ld_err   = err_q;
  assign ld_data  = data_q;

endmodule

// File: tb/tb_load_controller.sv
// Self-checking bench for load_controller: a transaction-level timeline model sets the expected
// outputs for every cycle, and a negedge process compares the DUT against it.
module tb_load_controller;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_start = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_funct3 = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ld_busy;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_err;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic        exp_req, exp_busy, exp_done, exp_err;
  logic [31:0] exp_addr, exp_data;
  logic [31:0] hold = '0;

  load_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_data(ld_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("mem_req", 32'(mem_req), 32'(exp_req));
      check_output("mem_addr", mem_addr, exp_addr);
      check_output("ld_busy", 32'(ld_busy), 32'(exp_busy));
      check_output("ld_done", 32'(ld_done), 32'(exp_done));
      check_output("ld_err", 32'(ld_err), 32'(exp_err));
      check_output("ld_data", ld_data, exp_data);
    end
  end

  // Legal funct3 and address a multiple of the access size.
  function automatic bit model_ok(input logic [31:0] a, input logic [2:0] f);
    int unsigned size;
    if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] model_ext(input logic [31:0] a, input logic [2:0] f,
                                            input logic [31:0] rd);
    logic [31:0]        shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    shifted = rd >> (8 * (a % 4));
    if (f == 3'd2) return rd;
    if (f[1:0] == 2'd0) begin
      sb = shifted[7:0];
      return f[2] ? (shifted & 32'hFF) : 32'(int'(sb));
    end
    sh = shifted[15:0];
    return f[2] ? (shifted & 32'hFFFF) : 32'(int'(sh));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic r, input logic [31:0] a, input logic b, input logic d,
                         input logic e, input logic [31:0] data);
    exp_req = r; exp_addr = a; exp_busy = b; exp_done = d; exp_err = e; exp_data = data;
  endtask

  task automatic noise();
    ld_start  = 1'($urandom_range(0, 1));
    ld_addr   = $urandom;
    ld_funct3 = 3'($urandom_range(0, 7));
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
  endtask

  // w = unacknowledged REQ cycles before ack; w >= T means the memory never answers.
  task automatic apply_stimulus(input logic [31:0] a, input logic [2:0] f, input logic [31:0] rd,
                                input int w, input int gap);
    int k;
    logic [31:0] wa;
    wa = a & ~32'h3;
    set_exp(0, 0, 0, 0, 0, hold);
    ld_start = 1'b1; ld_addr = a; ld_funct3 = f;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    step();
    if (!model_ok(a, f)) begin
      hold = 0;
      set_exp(0, 0, 1, 1, 1, 0);
      noise();
      step();
    end else begin
      k = (w < T) ? w + 1 : T;
      for (int c = 1; c <= k; c++) begin
        set_exp(1, wa, 1, 0, 0, hold);
        noise();
        mem_ack = (c == w + 1);
        mem_rdata = (c == w + 1) ? rd : $urandom;
        step();
      end
      if (w < T) begin
        hold = model_ext(a, f, rd);
        set_exp(0, 0, 1, 1, 0, hold);
        noise();
      end else begin
        hold = 0;
        set_exp(0, 0, 1, 1, 1, 0);
        noise();
        mem_ack = 1'b1;
      end
      step();
    end
    for (int g = 0; g < gap; g++) begin
      set_exp(0, 0, 0, 0, 0, hold);
      ld_start = 1'b0; ld_addr = $urandom; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      step();
    end
    ld_start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    #1 rst_n = 1'b0;
    #2;
    check_output("rst_mem_req", 32'(mem_req), 0);
    check_output("rst_ld_busy", 32'(ld_busy), 0);
    check_output("rst_ld_data", ld_data, 0);
    hold = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    check_output("pin_lb", model_ext(32'h1003, 3'd0, 32'h80AA55CC), 32'hFFFFFF80);
    check_output("pin_lbu", model_ext(32'h1001, 3'd4, 32'h80AA55CC), 32'h00000055);
    check_output("pin_lh", model_ext(32'h2002, 3'd1, 32'hBEEF1234), 32'hFFFFBEEF);
    check_output("pin_lhu", model_ext(32'h2002, 3'd5, 32'hBEEF1234), 32'h0000BEEF);
    check_output("pin_lw_mis", 32'(model_ok(32'h2001, 3'd2)), 0);

    apply_stimulus(32'h1003, 3'd0, 32'h80AA55CC, 0, 1);
    check_output("lb_data", ld_data, 32'hFFFFFF80);
    apply_stimulus(32'h1001, 3'd4, 32'h80AA55CC, 3, 1);
    check_output("lbu_data", ld_data, 32'h00000055);
    apply_stimulus(32'h2002, 3'd1, 32'hBEEF1234, 1, 0);
    apply_stimulus(32'h2002, 3'd5, 32'hBEEF1234, 0, 1);
    check_output("lhu_data", ld_data, 32'h0000BEEF);
    apply_stimulus(32'h2000, 3'd2, 32'hBEEF1234, 2, 1);
    check_output("lw_data", ld_data, 32'hBEEF1234);
    apply_stimulus(32'h2001, 3'd2, 32'h0, 0, 0);
    apply_stimulus(32'h2000, 3'd3, 32'h0, 0, 1);
    check_output("illegal_data", ld_data, 0);
    apply_stimulus(32'h3004, 3'd2, 32'h12345678, 0, 0);
    apply_stimulus(32'h4000, 3'd2, 32'hCAFEF00D, T, 2);
    check_output("timeout_data", ld_data, 0);

    // Reset in the middle of REQ must drop mem_req at once and swallow the load.
    set_exp(0, 0, 0, 0, 0, hold);
    ld_start = 1'b1; ld_addr = 32'h3000; ld_funct3 = 3'd2; mem_ack = 1'b0;
    step();
    ld_start = 1'b0;
    set_exp(1, 32'h3000, 1, 0, 0, hold);
    step();
    step();
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("arst_mem_req", 32'(mem_req), 0);
    check_output("arst_mem_addr", mem_addr, 0);
    check_output("arst_ld_busy", 32'(ld_busy), 0);
    check_output("arst_ld_done", 32'(ld_done), 0);
    hold = 0;
    set_exp(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    mem_ack = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    apply_stimulus(32'h5002, 3'd0, 32'h00C30000, 0, 1);
    check_output("post_rst_lb", ld_data, 32'hFFFFFFC3);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      apply_stimulus(ra, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, T + 1),
                     $urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_controller.md
LOAD_CONTROLLER -- requirements
Module: load_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles of mem_req without mem_ack before abort; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ld_start  input  1  load request; sampled only in IDLE.
REQ-005 ld_addr  input  32  byte address of load.
REQ-006 ld_funct3  input  3  RV32I load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 mem_req  output  1  memory read request; held until acknowledged.
REQ-008 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-009 mem_ack  input  1  memory read acknowledge; mem_rdata valid in same cycle.
REQ-010 mem_rdata  input  32  memory read word.
REQ-011 ld_busy  output  1  high while not in IDLE.
REQ-012 ld_done  output  1  one-cycle completion pulse.
REQ-013 ld_data  output  32  extended load result; valid when ld_done high, held until next ld_done.
REQ-014 ld_err  output  1  misaligned, illegal funct3 or timeout; valid only with ld_done.

Function
REQ-015 FSM states IDLE, REQ, RESP, FAIL; one state register, registered outputs.
REQ-016 IDLE + ld_start=1 (cycle N): latch ld_addr, ld_funct3; if legal and aligned -> REQ, else -> FAIL.
REQ-017 Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=00. Illegal: funct3 011, 110, 111.
REQ-018 REQ: mem_req=1 and mem_addr valid from cycle N+1; mem_req held until mem_ack sampled high.
REQ-019 mem_ack high in REQ at cycle M: capture mem_rdata, -> RESP; mem_req low from cycle M+1.
REQ-020 RESP (cycle M+1): ld_done=1, ld_err=0, ld_data=extended value; -> IDLE. Minimum latency start-to-done = 2 cycles with zero-wait ack at N+1.
REQ-021 FAIL: ld_done=1, ld_err=1, ld_data=0 for one cycle; -> IDLE; no memory request issued for misaligned/illegal.
REQ-022 Byte select: lane=addr[1:0], byte=rdata[8*lane+7:8*lane]; half select: addr[1]=0 -> rdata[15:0], 1 -> rdata[31:16].
REQ-023 Extension: funct3[2]=0 replicate MSB of selected byte/half into upper bits; funct3[2]=1 zero-fill; LW passes word unchanged.
REQ-024 Wait counter 8 bits, cleared on entry to REQ, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES -> FAIL, mem_req dropped next cycle.
REQ-025 mem_ack in same cycle counter reaches TIMEOUT_CYCLES: ack wins, normal completion.
REQ-026 mem_ack outside REQ ignored; ld_start outside IDLE ignored, no queueing.
REQ-027 ld_start in the IDLE cycle immediately after RESP/FAIL accepted normally (back-to-back, one idle cycle between done and next mem_req).
REQ-028 mem_addr held stable throughout REQ; 0 when mem_req=0.

Reset
REQ-029 rst_n=0 forces IDLE immediately, asynchronously: mem_req=0, mem_addr=0, ld_busy=0, ld_done=0, ld_err=0, ld_data=0, counter=0.
REQ-030 Reset mid-REQ aborts the load: no ld_done produced; later mem_ack ignored.
REQ-031 First ld_start accepted on first rising edge after rst_n deasserts.

Verification
REQ-032 LB addr 0x1003, rdata 0x80AA55CC, ack at N+1 -> mem_addr 0x1000, ld_done at N+2, ld_data 0xFFFFFF80, ld_err 0.
REQ-033 LBU addr 0x1001, rdata 0x80AA55CC, ack after 3 wait cycles -> ld_data 0x00000055, mem_req high exactly 4 cycles.
REQ-034 LH addr 0x2002, rdata 0xBEEF1234 -> ld_data 0xFFFFBEEF; LHU same -> 0x0000BEEF; LW addr 0x2000 -> 0xBEEF1234.
REQ-035 LW addr 0x2001 and funct3 011 -> mem_req never asserted, ld_done+ld_err at N+1, ld_data 0.
REQ-036 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then ld_done+ld_err, ld_data 0; late ack ignored.
REQ-037 rst_n low during REQ -> mem_req 0 with no clock edge, no ld_done; new LB after release completes correctly.
